// File: rtl/act_share_arbiter.sv
// Round-robin sharing of one fixed-latency activation unit between requesters.
// Credit-checked issue, tag pipeline steering, per-requester result FIFOs.
module act_share_arbiter #(
    parameter int DATA_W    = 8,
    parameter int NUM_REQ   = 4,
    parameter int ACT_LAT   = 2,
    parameter int RES_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        act_i_valid,
    output logic [DATA_W-1:0]           act_i_data,
    input  logic                        act_o_valid,
    input  logic [DATA_W-1:0]           act_o_data,
    output logic [NUM_REQ-1:0]          res_valid,
    output logic [NUM_REQ*DATA_W-1:0]   res_data,
    input  logic [NUM_REQ-1:0]          res_ready,
    output logic                        busy,
    output logic                        err_tag
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = $clog2(RES_DEPTH + 1);

    logic [CW-1:0]     occ_q  [NUM_REQ];
    logic [CW-1:0]     occ_d  [NUM_REQ];
    logic [CW-1:0]     infl_q [NUM_REQ];
    logic [CW-1:0]     infl_d [NUM_REQ];
    logic [PW-1:0]     wptr_q [NUM_REQ];
    logic [PW-1:0]     wptr_d [NUM_REQ];
    logic [PW-1:0]     rptr_q [NUM_REQ];
    logic [PW-1:0]     rptr_d [NUM_REQ];
    logic [DATA_W-1:0] mem_q  [NUM_REQ][RES_DEPTH];

    logic              tag_v_q   [ACT_LAT];
    logic [IW-1:0]     tag_idx_q [ACT_LAT];

    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic              err_q, err_d;
    logic [NUM_REQ-1:0] elig, wr, pop;
    logic              exit_v;
    logic [IW-1:0]     exit_idx;

    assign exit_v   = tag_v_q[ACT_LAT-1];
    assign exit_idx = tag_idx_q[ACT_LAT-1];

    // Credits come from registered counters only; rst_n gates grants in reset.
    always_comb begin
        elig = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            elig[k] = rst_n && req_valid[k] &&
                (({1'b0, occ_q[k]} + {1'b0, infl_q[k]}) < (CW+1)'(RES_DEPTH));
        end
    end

    always_comb begin
        int idx;
        idx       = 0;
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!gnt_vld && elig[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(idx);
            end
        end
        if (gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    assign act_i_valid = gnt_vld;
    assign act_i_data  = gnt_vld ? req_data[gnt_idx*DATA_W +: DATA_W] : '0;

    always_comb begin
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_comb begin
        err_d = err_q | (exit_v != act_o_valid);
        wr    = '0;
        pop   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            wr[k]     = exit_v && act_o_valid && (exit_idx == IW'(k));
            pop[k]    = res_ready[k] && (occ_q[k] != '0);
            occ_d[k]  = occ_q[k] + CW'(wr[k]) - CW'(pop[k]);
            infl_d[k] = infl_q[k] + CW'(req_ready[k])
                      - CW'(exit_v && (exit_idx == IW'(k)));
            wptr_d[k] = wptr_q[k] + PW'(wr[k]);
            rptr_d[k] = rptr_q[k] + PW'(pop[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q  <= '0;
            err_q <= 1'b0;
            for (int k = 0; k < NUM_REQ; k++) begin
                occ_q[k]  <= '0;
                infl_q[k] <= '0;
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
            for (int j = 0; j < ACT_LAT; j++) begin
                tag_v_q[j]   <= 1'b0;
                tag_idx_q[j] <= '0;
            end
        end else begin
            rr_q  <= rr_d;
            err_q <= err_d;
            for (int k = 0; k < NUM_REQ; k++) begin
                occ_q[k]  <= occ_d[k];
                infl_q[k] <= infl_d[k];
                wptr_q[k] <= wptr_d[k];
                rptr_q[k] <= rptr_d[k];
            end
            tag_v_q[0]   <= act_i_valid;
            tag_idx_q[0] <= gnt_idx;
            for (int j = 1; j < ACT_LAT; j++) begin
                tag_v_q[j]   <= tag_v_q[j-1];
                tag_idx_q[j] <= tag_idx_q[j-1];
            end
        end
    end

    // Storage needs no reset: heads are masked while a FIFO is empty.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_REQ; k++) begin
            if (wr[k]) mem_q[k][wptr_q[k]] <= act_o_data;
        end
    end

    always_comb begin
        res_valid = '0;
        res_data  = '0;
        busy      = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            res_valid[k] = (occ_q[k] != '0);
            if (res_valid[k]) res_data[k*DATA_W +: DATA_W] = mem_q[k][rptr_q[k]];
            busy = busy | (occ_q[k] != '0) | (infl_q[k] != '0);
        end
    end

    assign err_tag = err_q;

endmodule

// File: tb/tb_act_share_arbiter.sv
// Directed bench for act_share_arbiter with a 2-stage hardsigmoid model.
// Unit model: y = (x >>> 3) + 0.5 in Q1.7.
module tb_act_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        act_i_valid;
    logic [7:0]  act_i_data;
    logic        act_o_valid;
    logic [7:0]  act_o_data;
    logic [3:0]  res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_ready;
    logic        busy;
    logic        err_tag;

    logic        inj;
    logic        s1v, s2v;
    logic [7:0]  s1d, s2d;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    act_share_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .act_i_valid (act_i_valid),
        .act_i_data  (act_i_data),
        .act_o_valid (act_o_valid),
        .act_o_data  (act_o_data),
        .res_valid   (res_valid),
        .res_data    (res_data),
        .res_ready   (res_ready),
        .busy        (busy),
        .err_tag     (err_tag)
    );

    function automatic logic [7:0] hs(input logic signed [7:0] x);
        logic signed [7:0] t;
        t = x >>> 3;
        return 8'(t + 8'sd64);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1v <= 1'b0; s2v <= 1'b0;
            s1d <= '0;   s2d <= '0;
        end else begin
            s1v <= act_i_valid;
            s1d <= hs(act_i_data);
            s2v <= s1v;
            s2d <= s1d;
        end
    end

    assign act_o_valid = s2v | inj;
    assign act_o_data  = s2d;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'h0);
        chk({tag, "_ivalid"}, 32'(act_i_valid), 32'h0);
        chk({tag, "_idata"}, 32'(act_i_data), 32'h0);
        chk({tag, "_rvalid"}, 32'(res_valid), 32'h0);
        chk({tag, "_rdata"}, res_data, 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_err"}, 32'(err_tag), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c1, cother, nres;
        logic [7:0] exp_d [4];
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        res_ready = '0;
        inj       = 1'b0;
        exp_d[0] = 8'h7F; exp_d[1] = 8'h80; exp_d[2] = 8'h00; exp_d[3] = 8'h08;
        #2;
        chk_reset_outs("rst0");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // single request, result 3 edges later
        req_valid = 4'b0001; req_data = 32'h0; res_ready = 4'hF;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        chk("t1_ivalid", 32'(act_i_valid), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("t1_busy_flight", 32'(busy), 32'h1);
        chk("t1_rvalid_e0", 32'(res_valid), 32'h0);
        tick();
        chk("t1_rvalid_e1", 32'(res_valid), 32'h0);
        tick();
        chk("t1_rvalid_e2", 32'(res_valid), 32'h1);
        chk("t1_rdata", 32'(res_data[7:0]), 32'h40);
        tick();
        chk("t1_busy_idle", 32'(busy), 32'h0);
        chk("t1_rvalid_pop", 32'(res_valid), 32'h0);

        // all four valid; pointer sits at 1 after the grant to 0
        res_ready = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            req_valid = 4'hF;
            req_data  = {exp_d[3], exp_d[2], exp_d[1], exp_d[0]};
            #1;
            chk("t2_grant", 32'(req_ready), 32'(4'b0001 << ((1 + i) % 4)));
            chk("t2_idata", 32'(act_i_data), 32'(exp_d[(1 + i) % 4]));
        end
        tick();
        req_valid = '0;
        tick(); tick();
        chk("t2_rvalid", 32'(res_valid), 32'hF);
        chk("t2_rdata0", res_data, 32'h4140304F);
        res_ready = 4'hF;
        tick();
        chk("t2_rdata1", res_data, 32'h4140304F);
        tick();
        chk("t2_drained", 32'(res_valid), 32'h0);

        // requester 1 backpressured
        res_ready = 4'b1101;
        c1 = 0; cother = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            req_valid = 4'hF;
            #1;
            if (req_ready[1]) c1++;
            if (req_ready[0] || req_ready[2] || req_ready[3]) cother++;
        end
        chk("t3_accepts1", 32'(c1), 32'd4);
        chk("t3_others", 32'(cother), 32'd20);
        chk("t3_ready1_low", 32'(req_ready[1]), 32'h0);
        tick();
        req_valid = 4'b0010; res_ready = 4'hF;
        #1;
        chk("t3_pop_cycle", 32'(req_ready), 32'h0);
        tick();
        res_ready = 4'b1101;
        #1;
        chk("t3_credit", 32'(req_ready), 32'h2);
        tick();
        chk("t3_full_again", 32'(req_ready), 32'h0);
        req_valid = '0; res_ready = 4'hF;
        for (int i = 0; i < 8; i++) tick();
        chk("t3_busy", 32'(busy), 32'h0);

        // back-to-back on requester 0
        nres = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            req_valid = (i < 8) ? 4'b0001 : 4'b0000;
            req_data  = {24'h0, 8'(-64 + i)};
            #1;
            if (i < 8) chk("t4_grant", 32'(req_ready), 32'h1);
            if (res_valid[0]) begin
                nres++;
                chk("t4_rdata", 32'(res_data[7:0]), 32'h38);
            end
        end
        chk("t4_count", 32'(nres), 32'd8);

        // spurious unit output
        tick();
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("t5_err", 32'(err_tag), 32'h1);
        chk("t5_nowrite", 32'(res_valid), 32'h0);
        tick(); tick();
        chk("t5_sticky", 32'(err_tag), 32'h1);

        // reset with two in flight and two buffered
        res_ready = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_valid = 4'b0011;
            req_data  = 32'h0;
        end
        tick();
        req_valid = '0;
        #1;
        chk("t6_partial", 32'(res_valid), 32'h3);
        rst_n = 1'b0;
        req_valid = 4'hF;
        #1;
        chk_reset_outs("t6_rst");
        tick();
        req_valid = '0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_nostale", 32'(res_valid), 32'h0);
        end
        chk("t6_err_clr", 32'(err_tag), 32'h0);
        req_valid = 4'hF;
        #1;
        chk("t6_rr0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
